baud_gen_os: RTL and testbench
==============================

Name: baud_gen_os

Overview:
- Parametrised successor to the fixed-divider UART baud enable generator.
- Produces three pulses from the 50 MHz system clock: an oversampling tick for the receiver, a mid-bit sample tick and a per-bit tick for the transmitter.
- Uses a fractional accumulator so that non-integer oversample periods have no long-term drift.
- Supports the five preset rates, a runtime custom divisor, glitch-free rate changes and phase resynchronisation for start-bit alignment.

Parameters:
- FRAC_W, 4: fractional bits of the divisor. The divisor is in fixed point, Q(DIV_W-FRAC_W).FRAC_W, in units of 1/2^FRAC_W clock cycles per oversample tick.
- DIV_W, 16: total divisor width, integer plus fractional bits.
- OVERSAMPLE, 16: oversample ticks per bit. Must be even and ≥4.
- P0, 434: preset divisor selected by BC=000 (115200 baud at 16x).
- P1, 217: preset divisor selected by BC=001.
- P2, 109: preset divisor selected by BC=010.
- P3, 72: preset divisor selected by BC=011.
- P4, 36: preset divisor selected by BC=100.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: count enable. When low, all counters hold.
- BC, input, 3: rate select. 000–100 select P0–P4; 101–111 select custom_div.
- custom_div, input, DIV_W: runtime divisor, used when BC ≥ 101.
- sync, input, 1: phase restart; clears the accumulator and the oversample count.
- os_tick, output, 1: one-cycle oversample pulse.
- mid_tick, output, 1: one-cycle pulse at the mid-bit sample point.
- bit_tick, output, 1: one-cycle pulse at the bit boundary.
- active_div, output, DIV_W: divisor currently in effect.

Behaviour:
- Pending divisor: selected from BC/custom_div combinationally each cycle.
- Clamp: any selected value below 2^(FRAC_W+1) (32 at default parameters) is replaced by 2^(FRAC_W+1). The minimum os_tick period is therefore 2 cycles.
- Reset (rst=1 at a clk edge):
  - acc=0, os_cnt=0.
  - os_tick, mid_tick and bit_tick are 0.
  - active_div loads the clamped pending divisor.
  - Reset overrides sync and en.
- Accumulator, on each edge with en=1 and sync=0:
  - Compute s = acc + 2^FRAC_W.
  - If s ≥ active_div: acc ← s − active_div and os_tick ← 1. Otherwise acc ← s and os_tick ← 0.
  - acc is DIV_W+1 bits and can never overflow.
- Outputs are registered. Each pulse is high for exactly the one cycle following the edge that detected the event.
- os_cnt (0..OVERSAMPLE-1) increments on each os_tick event and wraps to 0.
- mid_tick: set with the os_tick event that moves os_cnt from OVERSAMPLE/2−1 to OVERSAMPLE/2.
- bit_tick: set with the os_tick event that wraps os_cnt from OVERSAMPLE−1 to 0.
- Bit period: exactly active_div clock cycles, because OVERSAMPLE·active_div/2^FRAC_W = active_div at default parameters. The j-th os_tick event falls on the smallest enabled edge k with k·2^FRAC_W ≥ j·active_div.
- Rate change: active_div ← pending only on:
  - the edge that raises bit_tick;
  - an edge with sync=1;
  - an edge with en=0.
  - BC or custom_div changes mid-bit never alter the current bit.
- sync=1 (and rst=0):
  - acc ← 0, os_cnt ← 0, active_div ← pending.
  - All ticks are 0 the next cycle, independent of en.
  - Counting restarts from the next enabled edge.
- en=0: acc and os_cnt hold and all ticks are 0. Counting resumes without phase loss when en returns high.
- os_tick, mid_tick and bit_tick can never be high in the same cycle as rst or sync.
- Illegal parameters (OVERSAMPLE odd, or DIV_W ≤ FRAC_W+1) are rejected at elaboration.

Test Plan:
- Nominal rate: rst, then BC=000, en=1. Require:
  - first os_tick on enabled edge 28;
  - os_tick gaps alternate 27/28 cycles;
  - mid_tick at edge 217;
  - bit_tick at edge 434 and every 434 cycles thereafter, with exactly 16 os_ticks per bit and zero drift over 100 bits.
- Rate change mid-bit: BC=000, switch BC to 011 at cycle 100. Require:
  - the first bit_tick still at 434;
  - active_div=72 after it;
  - subsequent bit_ticks every 72 cycles, the first at 506.
- Resync: pulse sync at cycle 300 of a bit with BC=001. Require:
  - no ticks in the following cycle;
  - mid_tick 109 enabled edges after sync (first edge k with 16k ≥ 8·217 = 1736);
  - bit_tick 217 edges after sync.
- Custom divisor clamp: BC=111, custom_div=20. Require active_div=32, os_tick every 2 cycles, bit_tick every 32 cycles. Then custom_div=868 requires bit_tick every 868 cycles after the next boundary.
- Enable gating: en low for 50 cycles mid-bit at BC=100. Require no ticks during the gap and the pending bit_tick delayed by exactly 50 cycles.
- Reset mid-operation: rst at cycle 200 of a bit. Require all ticks 0 the next cycle, then a fresh sequence with the first os_tick on edge 28 (BC=000). Also assert rst and sync together and require reset behaviour.

Source files
------------

// File: rtl/baud_gen_os.sv
// baud_gen_os
//   Oversampling UART baud enable generator. A fractional accumulator
//   divides the system clock by a fixed-point divisor and produces:
//     os_tick  - one pulse per oversample period (receiver sampling)
//     mid_tick - one pulse at the mid-bit sample point
//     bit_tick - one pulse per bit boundary (transmitter)
//   The divisor comes from one of five presets or from a runtime custom
//   value. It is clamped to a minimum of two clock cycles per oversample
//   tick. It is only swapped at a bit boundary, on sync, while disabled
//   or in reset, so a rate change never distorts a bit in flight.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   count enable; counters hold and ticks are 0 while low
//   BC         in   rate select: 0..4 -> P0..P4, 5..7 -> custom_div
//   custom_div in   runtime divisor, Q(DIV_W-FRAC_W).FRAC_W
//   sync       in   phase restart (accumulator and oversample count cleared)
//   os_tick    out  one-cycle oversample pulse
//   mid_tick   out  one-cycle mid-bit pulse
//   bit_tick   out  one-cycle bit-boundary pulse
//   active_div out  divisor currently in effect

module baud_gen_os #(
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned P0         = 434,
  parameter int unsigned P1         = 217,
  parameter int unsigned P2         = 109,
  parameter int unsigned P3         = 72,
  parameter int unsigned P4         = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       BC,
  input  logic [DIV_W-1:0] custom_div,
  input  logic             sync,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic [DIV_W-1:0] active_div
);

  // Reject parameter sets the counters cannot represent.
  if (((OVERSAMPLE % 2) != 0) || (OVERSAMPLE < 4) || (DIV_W <= FRAC_W + 1)) begin : g_param_check
    $error("baud_gen_os: OVERSAMPLE must be even and >= 4, and DIV_W > FRAC_W+1");
  end

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  // Smallest legal divisor: two clock cycles per oversample tick.
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2 ** (FRAC_W + 1));
  // One clock cycle expressed in divisor units.
  localparam logic [DIV_W:0]   STEP    = (DIV_W + 1)'(2 ** FRAC_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] sel_div;
  logic [DIV_W-1:0] pending_div;
  logic [DIV_W:0]   acc;
  logic [DIV_W:0]   sum;
  logic [CNT_W-1:0] os_cnt;
  logic             os_event;
  logic             cnt_wrap;
  logic             cnt_mid;

  // Rate selection.
  always_comb begin
    sel_div = custom_div;
    case (BC)
      3'd0:    sel_div = DIV_W'(P0);
      3'd1:    sel_div = DIV_W'(P1);
      3'd2:    sel_div = DIV_W'(P2);
      3'd3:    sel_div = DIV_W'(P3);
      3'd4:    sel_div = DIV_W'(P4);
      default: sel_div = custom_div;
    endcase
  end

  always_comb begin
    pending_div = sel_div;
    if (sel_div < MIN_DIV) begin
      pending_div = MIN_DIV;
    end
  end

  // acc stays below the largest divisor seen, so acc + STEP always fits
  // in DIV_W+1 bits.
  always_comb begin
    sum      = acc + STEP;
    os_event = (sum >= {1'b0, active_div});
    cnt_wrap = (os_cnt == CNT_LAST);
    cnt_mid  = (os_cnt == CNT_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      os_cnt     <= '0;
      os_tick    <= 1'b0;
      mid_tick   <= 1'b0;
      bit_tick   <= 1'b0;
      active_div <= pending_div;
    end else if (sync || !en) begin
      // Idle or restarting: safe point to take a new divisor. Only sync
      // discards phase; a plain disable keeps it for a seamless resume.
      if (sync) begin
        acc    <= '0;
        os_cnt <= '0;
      end
      os_tick    <= 1'b0;
      mid_tick   <= 1'b0;
      bit_tick   <= 1'b0;
      active_div <= pending_div;
    end else if (os_event) begin
      acc      <= sum - {1'b0, active_div};
      os_cnt   <= cnt_wrap ? '0 : os_cnt + 1'b1;
      os_tick  <= 1'b1;
      mid_tick <= cnt_mid;
      bit_tick <= cnt_wrap;
      if (cnt_wrap) begin
        active_div <= pending_div;
      end
    end else begin
      acc      <= sum;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen_os.sv
// tb_baud_gen_os
//   Directed bench for baud_gen_os at default parameters. Tick edges are
//   counted from the first enabled clock edge; expected oversample edges
//   follow ceil(j*div/16).

module tb_baud_gen_os;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  BC = 3'd0;
  logic [15:0] custom_div = '0;
  logic        sync = 1'b0;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [15:0] active_div;

  int n_cmp = 0;
  int n_err = 0;

  baud_gen_os dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .BC         (BC),
    .custom_div (custom_div),
    .sync       (sync),
    .os_tick    (os_tick),
    .mid_tick   (mid_tick),
    .bit_tick   (bit_tick),
    .active_div (active_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Step edges until the selected tick (0=os, 1=mid, 2=bit) is seen.
  // n = edges stepped, or -1 if the limit expired.
  task automatic wait_for(input int sel, input int limit, output int n, output int os_seen);
    bit done;
    n = 0;
    os_seen = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (os_tick) os_seen++;
      if ((sel == 0 && os_tick) || (sel == 1 && mid_tick) || (sel == 2 && bit_tick)) begin
        done = 1'b1;
      end else if (n >= limit) begin
        n = -1;
        done = 1'b1;
      end
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [2:0] bc, input logic [15:0] cdiv);
    en = 1'b0;
    sync = 1'b0;
    BC = bc;
    custom_div = cdiv;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int os;
    int edge_no;
    int os_total;
    int bad;

    // Reset state and nominal 115200 timing.
    do_reset(3'd0, 16'd0);
    check("rst_os", os_tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_bit", bit_tick, 0);
    check("rst_div", active_div, 434);
    en = 1'b1;
    edge_no = 0;
    for (int j = 1; j <= 16; j++) begin
      wait_for(0, 100, n, os);
      edge_no += n;
      check($sformatf("nom_os_edge%0d", j), edge_no, (j * 434 + 15) / 16);
      check($sformatf("nom_mid%0d", j), mid_tick, (j == 8) ? 1 : 0);
      check($sformatf("nom_bit%0d", j), bit_tick, (j == 16) ? 1 : 0);
    end
    os_total = 0;
    for (int b = 0; b < 99; b++) begin
      wait_for(2, 1000, n, os);
      check($sformatf("nom_bit_gap%0d", b), n, 434);
      os_total += os;
    end
    check("nom_os_per_99_bits", os_total, 99 * 16);

    // Mid-bit rate change takes effect only at the next boundary.
    do_reset(3'd0, 16'd0);
    en = 1'b1;
    step(100);
    BC = 3'd3;
    step(1);
    check("rc_div_hold", active_div, 434);
    wait_for(2, 1000, n, os);
    check("rc_first_bit", n, 434 - 101);
    check("rc_div_new", active_div, 72);
    wait_for(2, 1000, n, os);
    check("rc_bit_506", n, 72);
    check("rc_os_per_bit", os, 16);
    wait_for(2, 1000, n, os);
    check("rc_bit_gap", n, 72);

    // Resync in the second bit at BC=001.
    do_reset(3'd1, 16'd0);
    en = 1'b1;
    step(300);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("sync_os_zero", os_tick, 0);
    check("sync_mid_zero", mid_tick, 0);
    check("sync_bit_zero", bit_tick, 0);
    wait_for(1, 1000, n, os);
    check("sync_mid_edge", n, 109);
    wait_for(2, 1000, n, os);
    check("sync_bit_edge", n, 217 - 109);

    // Custom divisor below the minimum is clamped.
    do_reset(3'd7, 16'd20);
    check("clamp_div", active_div, 32);
    en = 1'b1;
    wait_for(0, 100, n, os);
    check("clamp_os1", n, 2);
    wait_for(0, 100, n, os);
    check("clamp_os2", n, 2);
    wait_for(2, 100, n, os);
    check("clamp_bit1", n, 28);
    wait_for(2, 100, n, os);
    check("clamp_bit2", n, 32);
    custom_div = 16'd868;
    wait_for(2, 100, n, os);
    check("cust_old_bit", n, 32);
    check("cust_div", active_div, 868);
    wait_for(2, 2000, n, os);
    check("cust_bit1", n, 868);
    wait_for(2, 2000, n, os);
    check("cust_bit2", n, 868);

    // Enable gap of 50 cycles, 10 edges into a 36-cycle bit.
    do_reset(3'd4, 16'd0);
    en = 1'b1;
    wait_for(2, 100, n, os);
    check("en_first_bit", n, 36);
    step(10);
    en = 1'b0;
    bad = 0;
    repeat (50) begin
      step(1);
      if (os_tick || mid_tick || bit_tick) bad++;
    end
    check("en_gap_ticks", bad, 0);
    en = 1'b1;
    wait_for(0, 100, n, os);
    check("en_resume_os", n, 2);
    wait_for(2, 100, n, os);
    check("en_delayed_bit", n, 24);

    // Reset mid-operation, then reset together with sync.
    do_reset(3'd0, 16'd0);
    en = 1'b1;
    step(200);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_os", os_tick, 0);
    check("mrst_mid", mid_tick, 0);
    check("mrst_bit", bit_tick, 0);
    wait_for(0, 100, n, os);
    check("mrst_first_os", n, 28);
    step(20);
    BC = 3'd3;
    rst = 1'b1;
    sync = 1'b1;
    step(1);
    rst = 1'b0;
    sync = 1'b0;
    check("rs_os", os_tick, 0);
    check("rs_bit", bit_tick, 0);
    check("rs_div", active_div, 72);
    wait_for(0, 100, n, os);
    check("rs_first_os", n, 5);
    wait_for(2, 200, n, os);
    check("rs_first_bit", n, 67);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
